// File: rtl/hkspi_slave_sync.sv
// hkspi_slave_sync: housekeeping SPI slave (mode 0) with pins oversampled on clock.
// Optional HKSPI_BYTE_COUNT_EN: cmd[5:3] limits the transfer to n data bytes.
module hkspi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMAND,
        S_ADDRESS,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sck_d;
    logic                   r_csb_d;

    logic       w_sck;
    logic       w_csb_hi;
    logic       w_sdi;
    logic       w_rise;
    logic       w_csb_fall;

    logic [6:0] r_shift;
    logic [2:0] r_bitcnt;
    logic [1:0] r_mode;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_re;
    logic       r_cap;
    logic [7:0] r_oshift;

    logic [7:0] w_byte;
    logic       w_done;
    logic       w_cmd_done;
    logic       w_addr_done;
    logic       w_data_done;
    logic       w_rd;
    logic       w_wr;
    logic       w_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_sync <= '0;
            r_csb_sync <= '1;
            r_sdi_sync <= '0;
            r_sck_d    <= 1'b0;
            r_csb_d    <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], csb};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_sck_d    <= w_sck;
            r_csb_d    <= w_csb_hi;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_csb_hi   = r_csb_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_rise     = w_sck & ~r_sck_d;
    assign w_csb_fall = r_csb_d & ~w_csb_hi;

    assign w_byte      = {r_shift, w_sdi};
    assign w_done      = w_rise && (r_bitcnt == 3'd7);
    assign w_cmd_done  = w_done && (r_state == S_COMMAND);
    assign w_addr_done = w_done && (r_state == S_ADDRESS);
    assign w_data_done = w_done && (r_state == S_DATA);
    assign w_rd        = r_mode[0];
    assign w_wr        = r_mode[1];

`ifdef HKSPI_BYTE_COUNT_EN
    logic [2:0] r_nbytes;
    logic [2:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_nbytes <= 3'd0;
            r_count  <= 3'd0;
        end else if (w_cmd_done) begin
            r_nbytes <= w_byte[5:3];
            r_count  <= 3'd0;
        end else if (w_data_done) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign w_last = (r_nbytes != 3'd0) && ((r_count + 3'd1) == r_nbytes);
`else
    assign w_last = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        sdo_oe = 1'b0;
        sdo    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_csb_fall) begin
                    w_next = S_COMMAND;
                end
            end
            S_COMMAND: begin
                if (w_done) begin
                    w_next = (w_byte[7:6] == 2'b00) ? S_IGNORE : S_ADDRESS;
                end
            end
            S_ADDRESS: begin
                if (w_done) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                sdo_oe = w_rd;
                if (w_done && w_last) begin
                    w_next = S_IGNORE;
                end
            end
            S_IGNORE: begin
                w_next = S_IGNORE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_csb_hi && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
        sdo = sdo_oe & r_oshift[7];
    end

    // Write modes strobe reg_we first and advance the address on the strobe,
    // so a read/write stream reads address A before writing it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_mode   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_cap    <= 1'b0;
            r_oshift <= '0;
        end else begin
            r_we  <= 1'b0;
            r_re  <= 1'b0;
            r_cap <= r_re;
            if (r_state == S_IDLE) begin
                r_bitcnt <= '0;
            end else if (w_rise) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_rise) begin
                r_shift <= w_byte[6:0];
            end
            if (w_cmd_done) begin
                r_mode <= w_byte[7:6];
            end
            if (w_addr_done) begin
                r_addr <= w_byte;
                r_re   <= w_rd && !w_csb_hi;
            end
            if (w_data_done) begin
                if (w_wr) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_byte;
                end else begin
                    r_addr <= r_addr + 8'd1;
                    r_re   <= !w_csb_hi && !w_last;
                end
            end
            if (r_we) begin
                r_addr <= r_addr + 8'd1;
                r_re   <= w_rd && (r_state == S_DATA) && !w_csb_hi;
            end
            if (r_cap) begin
                r_oshift <= reg_rdata;
            end else if (w_rise && (r_state == S_DATA) && w_rd) begin
                r_oshift <= {r_oshift[6:0], 1'b0};
            end
        end
    end

    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = ~w_csb_hi;

endmodule

// File: tb/tb_hkspi_slave_sync.sv
// tb_hkspi_slave_sync: SPI master model, register-file model and strobe scoreboard.
// Define HKSPI_BYTE_COUNT_EN here as for the DUT to check the byte-count build.
module tb_hkspi_slave_sync;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sck = 1'b0;
    logic       csb = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo;
    logic       sdo_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    hkspi_slave_sync #(.SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sck       (sck),
        .csb       (csb),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        sbq[$];
    logic [7:0] rxq[$];
    logic [7:0] rf [0:255];
    logic [7:0] gm [0:255];
    logic [7:0] txd[0:31];

    always @(posedge clock) begin
        if (reg_we) rf[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= rf[reg_addr];
    end

    always @(negedge clock) begin : mon
        ev_t e;
        if (reset_n && (reg_we || reg_re)) begin
            check("we_re_excl", 32'(reg_we & reg_re), 32'd0);
            check("sb_pending", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("strobe_kind", 32'(reg_we), 32'(e.we));
                check("strobe_addr", 32'(reg_addr), 32'(e.addr));
                if (e.we) check("strobe_wdata", 32'(reg_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input bit last,
                             output logic [7:0] rx, output int oe_cnt);
        rx = 8'h00;
        oe_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            sdi = tx[i];
            tick(6);
            rx[i] = sdo;
            oe_cnt += int'(sdo_oe);
            sck = 1'b1;
            if (last && i == 0) csb = 1'b1;
            tick(6);
            sck = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int nb);
        for (int i = 7; i > 7 - nb; i--) begin
            sdi = v[i];
            tick(6);
            sck = 1'b1;
            tick(6);
            sck = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr,
                           input int n);
        logic [7:0] a;
        logic [7:0] rx;
        logic [7:0] exp;
        int oe;
        int lim;
        int eff;
        bit rd;
        bit wr;
        rd = cmd[6];
        wr = cmd[7];
`ifdef HKSPI_BYTE_COUNT_EN
        lim = int'(cmd[5:3]);
`else
        lim = 0;
`endif
        eff = (lim != 0 && lim < n) ? lim : n;
        a = addr;
        for (int k = 0; k < eff; k++) begin
            if (rd) begin
                sbq.push_back('{we: 1'b0, addr: a, data: 8'h00});
                rxq.push_back(gm[a]);
            end
            if (wr) begin
                sbq.push_back('{we: 1'b1, addr: a, data: txd[k]});
                gm[a] = txd[k];
            end
            a = a + 8'd1;
        end
        csb = 1'b0;
        tick(6);
        check("busy_sel", 32'(busy), 32'd1);
        xfer_byte(cmd, 1'b0, rx, oe);
        check("cmd_oe", 32'(oe), 32'd0);
        xfer_byte(addr, n == 0, rx, oe);
        check("addr_oe", 32'(oe), 32'd0);
        for (int k = 0; k < n; k++) begin
            xfer_byte(txd[k], k == n - 1, rx, oe);
            if (rd && k < eff) begin
                exp = rxq.pop_front();
                check("rdata", 32'(rx), 32'(exp));
                check("data_oe", 32'(oe), 32'd8);
            end else begin
                check("data_oe", 32'(oe), 32'd0);
            end
        end
        tick(8);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        check("end_oe", 32'(sdo_oe), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        int oe;
        for (int i = 0; i < 256; i++) begin
            rf[i] = 8'((i * 37 + 5) ^ 8'h3C);
        end
        rf[0] = 8'h00;
        rf[1] = 8'h04;
        rf[2] = 8'h56;
        rf[3] = 8'h11;
        rf[8'h12] = 8'h04;
        for (int i = 0; i < 256; i++) gm[i] = rf[i];
        for (int i = 0; i < 32; i++) txd[i] = 8'h00;

        reset_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sck = 1'($urandom_range(0, 1));
            csb = 1'($urandom_range(0, 1));
            sdi = 1'($urandom_range(0, 1));
            tick(1);
            check("rst_outputs",
                  32'({sdo, sdo_oe, reg_we, reg_re, busy, reg_addr, reg_wdata}),
                  32'd0);
        end
        sck = 1'b0;
        csb = 1'b1;
        sdi = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(6);

        run_txn(8'h40, 8'h03, 1);

        txd[0] = 8'h01;
        run_txn(8'h80, 8'h0B, 1);
        txd[0] = 8'h00;
        run_txn(8'h80, 8'h0B, 1);

        for (int i = 0; i < 32; i++) txd[i] = 8'h00;
        run_txn(8'h40, 8'h00, 19);
        run_txn(8'h40, 8'hFE, 3);

        run_txn(8'h00, 8'h05, 1);

        csb = 1'b0;
        tick(6);
        xfer_byte(8'h80, 1'b0, rx, oe);
        xfer_byte(8'h10, 1'b0, rx, oe);
        send_bits(8'hE8, 5);
        tick(2);
        csb = 1'b1;
        tick(8);
        check("abort_addr_hold", 32'(reg_addr), 32'h10);
        check("abort_sb", 32'(sbq.size()), 32'd0);
        run_txn(8'h40, 8'h03, 1);

        csb = 1'b0;
        tick(6);
        xfer_byte(8'h80, 1'b0, rx, oe);
        xfer_byte(8'h20, 1'b0, rx, oe);
        send_bits(8'h77, 3);
        sck = 1'b1;
        tick(2);
        reset_n = 1'b0;
        #1;
        check("midrst_addr", 32'(reg_addr), 32'd0);
        check("midrst_flags", 32'({sdo, sdo_oe, reg_we, reg_re, busy}), 32'd0);
        sck = 1'b0;
        csb = 1'b1;
        tick(4);
        reset_n = 1'b1;
        tick(8);
        check("midrst_sb", 32'(sbq.size()), 32'd0);

        txd[0] = 8'h5A;
        txd[1] = 8'hA5;
        run_txn(8'hC0, 8'h30, 2);
        run_txn(8'h40, 8'h30, 2);

        txd[0] = 8'hAA;
        txd[1] = 8'h55;
        run_txn(8'h88, 8'h20, 2);
        txd[0] = 8'h00;
        txd[1] = 8'h00;
        run_txn(8'h40, 8'h20, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
